// File: rtl/fifo_stream_reader.sv
// Drains the read side of a FIFO (registered or showahead mode) into a
// valid/ready stream with packet framing, through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned SHOWAHEAD = 0,
  parameter int unsigned PKT_LEN   = 4,
  parameter int unsigned CWIDTH    = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_req_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [CWIDTH-1:0] pkt_cnt_o
);

  localparam int unsigned WCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_LEN - 1);

  logic [DWIDTH-1:0] tail_q, head_d, tail_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              inflight_q;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [1:0]        occ;
  logic              pop, push, eop_pop;

  assign pop     = valid_o & ready_i;
  assign occ     = buf_cnt_q + {1'b0, inflight_q};
  assign eop_pop = pop & (word_cnt_q == LAST_WORD);

  // Request only while the words already owed still fit after this cycle's pop.
  assign fifo_rd_req_o = srst_i & ~fifo_empty_i & ((occ - {1'b0, pop}) <= 2'd1);

  // Showahead data is valid with the request; registered data one cycle later.
  if (SHOWAHEAD != 0) begin : g_showahead
    assign push = fifo_rd_req_o;
  end else begin : g_registered
    assign push = inflight_q;
  end

  // Skid buffer and framing next-state.
  always_comb begin
    buf_cnt_d  = buf_cnt_q;
    head_d     = data_o;
    tail_d     = tail_q;
    word_cnt_d = word_cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) head_d = fifo_q_i;
        else                   tail_d = fifo_q_i;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d    = tail_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          head_d = fifo_q_i;
        end else begin
          head_d = tail_q;
          tail_d = fifo_q_i;
        end
      end
      default: ;
    endcase
    if (pop) word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + WCW'(1);
  end

  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      buf_cnt_q  <= '0;
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
      tail_q     <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      pkt_cnt_o  <= '0;
    end else begin
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= (SHOWAHEAD == 0) ? fifo_rd_req_o : 1'b0;
      word_cnt_q <= word_cnt_d;
      tail_q     <= tail_d;
      data_o     <= head_d;
      valid_o    <= (buf_cnt_d != 2'd0);
      sop_o      <= (buf_cnt_d != 2'd0) & (word_cnt_d == '0);
      eop_o      <= (buf_cnt_d != 2'd0) & (word_cnt_d == LAST_WORD);
      pkt_cnt_o  <= pkt_cnt_o + CWIDTH'(eop_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!srst_i)
    !(push && !pop && buf_cnt_q == 2'd2));
  a_no_req_empty: assert property (@(posedge clk_i) disable iff (!srst_i)
    !(fifo_rd_req_o && fifo_empty_i));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: dut0 = registered FIFO, PKT_LEN 4, 16-bit count;
// dut1 = showahead FIFO, PKT_LEN 1, 2-bit count.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n_a [2];
  logic        ready_a [2];
  logic        empty_a [2];
  logic        req_a   [2];
  logic        valid_a [2];
  logic        sop_a   [2];
  logic        eop_a   [2];
  logic [7:0]  data_a  [2];
  logic [7:0]  q0, q1;
  logic [15:0] pkt0;
  logic [1:0]  pkt1;

  // FIFO contents model: words [fhead, ftail) still in the FIFO
  logic [7:0] fmem [2][64];
  int         fhead [2];
  int         ftail [2];

  // Stream model: words [eidx, fhead) have left the FIFO but not the stream
  int         eidx  [2];
  int         widx  [2];
  int         mpkt  [2];
  logic       req_seen [2];
  logic       pstall [2];
  logic [7:0] pdata [2];
  logic       psop [2];
  logic       peop [2];

  int n_checks;
  int n_fail;

  // results of collect()
  logic [7:0] c_dat [16];
  logic       c_sop [16];
  logic       c_eop [16];
  int         c_cyc [16];
  int         c_pkt [16];
  int         c_n, c_fr, c_fv;

  assign empty_a[0] = (fhead[0] == ftail[0]);
  assign empty_a[1] = (fhead[1] == ftail[1]);
  assign q1 = empty_a[1] ? 8'hEE : fmem[1][fhead[1]];

  fifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD(0), .PKT_LEN(4), .CWIDTH(16)) u_dut0 (
    .clk_i(clk), .srst_i(rst_n_a[0]), .fifo_q_i(q0), .fifo_empty_i(empty_a[0]),
    .fifo_rd_req_o(req_a[0]), .data_o(data_a[0]), .valid_o(valid_a[0]),
    .ready_i(ready_a[0]), .sop_o(sop_a[0]), .eop_o(eop_a[0]), .pkt_cnt_o(pkt0));

  fifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD(1), .PKT_LEN(1), .CWIDTH(2)) u_dut1 (
    .clk_i(clk), .srst_i(rst_n_a[1]), .fifo_q_i(q1), .fifo_empty_i(empty_a[1]),
    .fifo_rd_req_o(req_a[1]), .data_o(data_a[1]), .valid_o(valid_a[1]),
    .ready_i(ready_a[1]), .sop_o(sop_a[1]), .eop_o(eop_a[1]), .pkt_cnt_o(pkt1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int plen(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int pmask(input int i);
    return (i == 0) ? 32'hFFFF : 32'h3;
  endfunction

  function automatic int pkt_of(input int i);
    return (i == 0) ? int'(pkt0) : int'(pkt1);
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got 0x%0h expected 0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic load(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      fmem[i][ftail[i]] = 8'(base + k);
      ftail[i]++;
    end
  endtask

  // Per-cycle comparison of one DUT against the stream model.
  task automatic mon(input int i);
    int   outst;
    logic pop;
    if (!rst_n_a[i]) begin
      chk("rst_valid", i, 32'(valid_a[i]), 0);
      chk("rst_sop", i, 32'(sop_a[i]), 0);
      chk("rst_eop", i, 32'(eop_a[i]), 0);
      chk("rst_pkt", i, 32'(pkt_of(i)), 0);
      chk("rst_req", i, 32'(req_a[i]), 0);
      eidx[i] = fhead[i];
      widx[i] = 0;
      mpkt[i] = 0;
      pstall[i] = 1'b0;
      req_seen[i] = 1'b0;
      return;
    end
    outst = fhead[i] - eidx[i];
    pop   = valid_a[i] & ready_a[i];
    if (req_a[i]) begin
      chk("req_while_empty", i, 32'(empty_a[i]), 0);
      chk("req_occ_le1", i, 32'((outst - int'(pop)) <= 1), 1);
    end
    chk("occ_le2", i, 32'(outst <= 2), 1);
    chk("pkt_cnt", i, 32'(pkt_of(i)), 32'(mpkt[i] & pmask(i)));
    if (pstall[i]) begin
      chk("stall_valid", i, 32'(valid_a[i]), 1);
      chk("stall_data", i, 32'(data_a[i]), 32'(pdata[i]));
      chk("stall_sop", i, 32'(sop_a[i]), 32'(psop[i]));
      chk("stall_eop", i, 32'(eop_a[i]), 32'(peop[i]));
    end
    if (valid_a[i]) begin
      if (eidx[i] < fhead[i]) begin
        chk("data", i, 32'(data_a[i]), 32'(fmem[i][eidx[i]]));
        chk("sop", i, 32'(sop_a[i]), 32'(widx[i] == 0));
        chk("eop", i, 32'(eop_a[i]), 32'(widx[i] == plen(i) - 1));
      end else begin
        chk("valid_no_word", i, 32'(valid_a[i]), 0);
      end
    end
    if (pop) begin
      eidx[i]++;
      if (widx[i] == plen(i) - 1) mpkt[i]++;
      widx[i] = (widx[i] + 1) % plen(i);
    end
    pstall[i]   = valid_a[i] & ~ready_a[i];
    pdata[i]    = data_a[i];
    psop[i]     = sop_a[i];
    peop[i]     = eop_a[i];
    req_seen[i] = req_a[i];
  endtask

  // FIFO read side: pop on a request seen before the edge.
  task automatic fifo_step(input int i);
    if (req_seen[i] && fhead[i] < ftail[i]) begin
      if (i == 0) q0 = fmem[0][fhead[0]];
      fhead[i]++;
    end else if (i == 0) begin
      q0 = 8'hEE;
    end
  endtask

  // Run until n pops on dut i (bounded); ends at posedge+1 after the last pop.
  task automatic collect(input int i, input int n, input int maxc, input bit toggle);
    bit pend;
    c_n = 0; c_fr = -1; c_fv = -1; pend = 0;
    for (int c = 0; c < maxc; c++) begin
      ready_a[i] = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (req_a[i] && c_fr < 0) c_fr = c;
      if (valid_a[i] && c_fv < 0) c_fv = c;
      if (valid_a[i] && ready_a[i]) begin
        c_dat[c_n] = data_a[i];
        c_sop[c_n] = sop_a[i];
        c_eop[c_n] = eop_a[i];
        c_cyc[c_n] = c;
        c_n++;
        pend = 1;
      end
      @(posedge clk);
      #1;
      if (pend) begin
        c_pkt[c_n-1] = pkt_of(i);
        pend = 0;
      end
      if (c_n == n) break;
    end
    chk("collect_count", i, 32'(c_n), 32'(n));
  endtask

  initial begin
    int nreq;
    n_checks = 0;
    n_fail   = 0;
    q0 = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      fhead[i] = 0; ftail[i] = 0; eidx[i] = 0; widx[i] = 0; mpkt[i] = 0;
      req_seen[i] = 1'b0; pstall[i] = 1'b0; pdata[i] = '0; psop[i] = 1'b0; peop[i] = 1'b0;
      rst_n_a[i] = 1'b0;
      ready_a[i] = 1'b0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) mon(i);
      end
      forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) fifo_step(i);
      end
    join_none

    // Words waiting in the FIFO during reset must not be requested.
    load(0, 8'h10, 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_forced_low", 0, 32'(req_a[0]), 0);
    chk("reset_valid", 0, 32'(valid_a[0]), 0);
    chk("reset_data", 0, 32'(data_a[0]), 0);
    chk("reset_pkt", 0, 32'(pkt0), 0);
    @(posedge clk);
    #1;
    rst_n_a[0] = 1'b1;
    rst_n_a[1] = 1'b1;

    // Full-rate stream, registered FIFO
    collect(0, 8, 40, 0);
    chk("t1_latency", 0, 32'(c_fv - c_fr), 2);
    chk("t1_back_to_back", 0, 32'(c_cyc[7] - c_cyc[0]), 7);
    for (int k = 0; k < 8; k++) begin
      chk("t1_data", 0, 32'(c_dat[k]), 32'(8'h10 + k));
      chk("t1_sop", 0, 32'(c_sop[k]), 32'(k == 0 || k == 4));
      chk("t1_eop", 0, 32'(c_eop[k]), 32'(k == 3 || k == 7));
    end
    chk("t1_pkt_cnt", 0, 32'(c_pkt[7]), 2);

    // Same stream with ready toggling 1,0,0,1
    load(0, 8'h10, 8);
    collect(0, 8, 80, 1);
    for (int k = 0; k < 8; k++) chk("t2_data", 0, 32'(c_dat[k]), 32'(8'h10 + k));
    chk("t2_pkt_cnt", 0, 32'(c_pkt[7]), 4);

    // Backpressure: ready low with 5 words queued
    ready_a[0] = 1'b0;
    load(0, 8'h30, 5);
    nreq = 0;
    repeat (6) begin
      @(negedge clk);
      nreq += int'(req_a[0]);
      @(posedge clk);
      #1;
    end
    chk("t4_req_count", 0, 32'(nreq), 2);
    @(negedge clk);
    chk("t4_hold_valid", 0, 32'(valid_a[0]), 1);
    chk("t4_hold_data", 0, 32'(data_a[0]), 32'h30);
    chk("t4_hold_sop", 0, 32'(sop_a[0]), 1);
    chk("t4_no_req_full", 0, 32'(req_a[0]), 0);
    @(posedge clk);
    #1;
    collect(0, 5, 20, 0);
    for (int k = 0; k < 5; k++) chk("t4_data", 0, 32'(c_dat[k]), 32'(8'h30 + k));
    chk("t4_pkt_cnt", 0, 32'(c_pkt[4]), 5);

    // Async reset with word_cnt=2 and a full buffer
    load(0, 8'h40, 8);
    collect(0, 1, 20, 0);
    chk("t5_first", 0, 32'(c_dat[0]), 32'h40);
    ready_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_pre_valid", 0, 32'(valid_a[0]), 1);
    chk("t5_pre_data", 0, 32'(data_a[0]), 32'h41);
    chk("t5_pre_sop", 0, 32'(sop_a[0]), 0);
    chk("t5_pre_eop", 0, 32'(eop_a[0]), 0);
    @(posedge clk);
    #3;
    rst_n_a[0] = 1'b0;
    #1;
    chk("t5_async_valid", 0, 32'(valid_a[0]), 0);
    chk("t5_async_sop", 0, 32'(sop_a[0]), 0);
    chk("t5_async_eop", 0, 32'(eop_a[0]), 0);
    chk("t5_async_pkt", 0, 32'(pkt0), 0);
    @(posedge clk);
    #3;
    rst_n_a[0] = 1'b1;
    collect(0, 5, 30, 0);
    chk("t5_resume_data", 0, 32'(c_dat[0]), 32'h43);
    chk("t5_resume_sop", 0, 32'(c_sop[0]), 1);
    chk("t5_pkt_cnt", 0, 32'(c_pkt[4]), 1);

    // Showahead FIFO, PKT_LEN 1, 2-bit packet count
    load(1, 8'hA0, 3);
    collect(1, 3, 20, 0);
    chk("t3_latency", 1, 32'(c_fv - c_fr), 1);
    chk("t3_back_to_back", 1, 32'(c_cyc[2] - c_cyc[0]), 2);
    for (int k = 0; k < 3; k++) begin
      chk("t3_data", 1, 32'(c_dat[k]), 32'(8'hA0 + k));
      chk("t3_sop", 1, 32'(c_sop[k]), 1);
      chk("t3_eop", 1, 32'(c_eop[k]), 1);
      chk("t6_pkt_seq", 1, 32'(c_pkt[k]), 32'(k + 1));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_drained_valid", 1, 32'(valid_a[1]), 0);
    chk("t3_drained_req", 1, 32'(req_a[1]), 0);
    @(posedge clk);
    #1;
    load(1, 8'hB0, 2);
    collect(1, 2, 20, 0);
    chk("t6_pkt_wrap", 1, 32'(c_pkt[0]), 0);
    chk("t6_pkt_after_wrap", 1, 32'(c_pkt[1]), 1);
    chk("t6_data", 1, 32'(c_dat[1]), 32'hB1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("end_drained0", 0, 32'(eidx[0] == ftail[0]), 1);
    chk("end_drained1", 1, 32'(eidx[1] == ftail[1]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drains the read side of a team FIFO (registered or showahead output mode) and presents its words as a valid/ready stream with packet framing. Tracks read latency and in-flight words, buffering them in a 2-entry output skid buffer, so it sustains 1 word/cycle and never drops data under backpressure. Sits between a `fifo` instance and any downstream consumer (serializer, packet sink).

Parameters:
- DWIDTH, 8, data word width; must match the FIFO.
- SHOWAHEAD, 0, FIFO output mode: 0 = data valid 1 cycle after rd_req; 1 = head word visible while not empty.
- PKT_LEN, 4, words per packet; must be >= 1.
- CWIDTH, 16, width of the completed-packet counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- srst_i  in  1  reset, asynchronous, active-low.
- fifo_q_i  in  DWIDTH  FIFO read data.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_req_o  out  1  FIFO read request / pop acknowledge.
- data_o  out  DWIDTH  stream data.
- valid_o  out  1  stream data valid.
- ready_i  in  1  downstream ready.
- sop_o  out  1  first word of packet; qualified by valid_o.
- eop_o  out  1  last word of packet; qualified by valid_o.
- pkt_cnt_o  out  CWIDTH  completed packets; wraps modulo 2^CWIDTH.

Behaviour:
- Reset (srst_i=0, asynchronous):
  - Outputs: valid_o=0, data_o=0, sop_o=0, eop_o=0, pkt_cnt_o=0; fifo_rd_req_o forced 0 combinationally.
  - Internal: skid buffer empty, in-flight flag cleared, word counter 0.
- Handshake:
  - A word transfers on a cycle where valid_o=1 and ready_i=1 (pop).
  - data_o, sop_o and eop_o hold stable while valid_o=1 and ready_i=0.
  - valid_o never deasserts without a pop.
- Occupancy: occ = buf_cnt (0..2) + inflight (0/1). inflight is used only when SHOWAHEAD=0.
- Request rule (combinational):
  - fifo_rd_req_o = srst_i & !fifo_empty_i & ((occ - pop) <= 1).
  - The rule guarantees the buffer never exceeds 2 entries.
  - fifo_rd_req_o is never asserted while fifo_empty_i=1.
- SHOWAHEAD=0:
  - Set inflight on a request.
  - Capture fifo_q_i into the buffer on the following cycle.
  - Read latency from rd_req to data_o is 2 cycles when the buffer is empty.
- SHOWAHEAD=1:
  - Capture fifo_q_i into the buffer in the same cycle as fifo_rd_req_o; inflight is always 0.
  - Latency is 1 cycle.
- Skid buffer is 2-entry, in order. valid_o = (buf_cnt != 0); data_o is the head entry, registered.
- Push and pop in the same cycle leave buf_cnt unchanged. With buf_cnt=0, a push lands directly in the head.
- Throughput: with ready_i held at 1 and the FIFO non-empty, one word per cycle after the initial latency.
- Framing:
  - word_cnt counts 0..PKT_LEN-1 and advances only on a pop, wrapping to 0 after PKT_LEN-1.
  - sop_o = (word_cnt==0); eop_o = (word_cnt==PKT_LEN-1).
  - PKT_LEN=1 gives sop_o=eop_o=1 on every word.
  - pkt_cnt_o increments on the pop of an eop word.
- FIFO empties mid-packet: valid_o drops after the buffer drains; word_cnt is held and the packet resumes when data returns.
- Reset mid-operation: buffered and in-flight words are discarded (the FIFO has already popped them). Framing restarts at sop.
- Assertions: no capture into a full buffer; no fifo_rd_req_o while fifo_empty_i=1.

Test Plan:
- Reset, then 8 words 0x10..0x17 in the FIFO, ready_i=1, SHOWAHEAD=0, PKT_LEN=4:
  - Required: data_o = 0x10..0x17 on 8 consecutive cycles, first valid 2 cycles after the first rd_req.
  - Required: sop_o on 0x10/0x14, eop_o on 0x13/0x17; pkt_cnt_o=2.
- Same stream with ready_i toggling 1,0,0,1 repeatedly:
  - Required: no loss or duplication, data held while stalled.
  - Required: fifo_rd_req_o never asserted with occ-pop=2.
- SHOWAHEAD=1, 3 words 0xA0..0xA2:
  - Required: first valid_o 1 cycle after the first rd_req, one word per cycle.
  - Required: valid_o=0 after 0xA2; no rd_req while fifo_empty_i=1.
- ready_i=0 with 5 words queued:
  - Required: exactly 2 rd_req issued, buffer full, valid_o=1 holding the first word.
  - Required: on release of ready_i, remaining words follow in order.
- srst_i pulsed low asynchronously mid-packet (word_cnt=2, buf_cnt=2):
  - Required: valid_o/sop_o/eop_o/pkt_cnt_o drop to 0 immediately.
  - Required: the next word after reset carries sop_o=1.
- CWIDTH=2, PKT_LEN=1, 5 words: pkt_cnt_o sequence 1,2,3,0,1.
